// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM encodings
// and a constant-width helper used to size the nibble counter.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Never returns less than 1, so a counter for a 1-value range still gets one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/parallel_adder.sv
// Combinational 4-bit adder with carry-in and carry-out; the one nibble-wide
// arithmetic stage reused by the serial adder.
module parallel_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c,
    output logic [3:0] sum,
    output logic       carry_out
);

    assign {carry_out, sum} = 5'(a) + 5'(b) + 5'(c);

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide unsigned adder that adds one nibble per clock through a single
// parallel_adder, LSB first, and reports the full sum with a one-cycle done pulse.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                      cin,
    output logic                      busy,
    output logic                      done,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                      cout
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int CW = clog2(NIBBLES);
    localparam logic [CW-1:0] LAST_NIBBLE = CW'(NIBBLES - 1);

    state_t state;
    state_t state_next;

    logic [W-1:0]        a_r;
    logic [W-1:0]        b_r;
    logic [W-1:0]        r_reg;
    logic [W-1:0]        r_next;
    logic                c_r;
    logic [CW-1:0]       cnt;
    logic [NIBBLE_W-1:0] add_sum;
    logic                add_cout;
    logic                accept;
    logic                last_nibble;

    parallel_adder u_parallel_adder (
        .a         (a_r[NIBBLE_W-1:0]),
        .b         (b_r[NIBBLE_W-1:0]),
        .c         (c_r),
        .sum       (add_sum),
        .carry_out (add_cout)
    );

    assign r_next = {add_sum, r_reg[W-1:NIBBLE_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (last_nibble) state_next = ST_DONE;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == ST_RUN);
        done        = (state == ST_DONE);
        accept      = start && (state == ST_IDLE || state == ST_DONE);
        last_nibble = (state == ST_RUN) && (cnt == LAST_NIBBLE);
    end

    // sum/cout only load on the final nibble, so they hold the previous
    // result through IDLE and while the next operation is still running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            r_reg <= '0;
            c_r   <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_r <= a;
            b_r <= b;
            c_r <= cin;
            cnt <= '0;
        end else if (state == ST_RUN) begin
            r_reg <= r_next;
            c_r   <= add_cout;
            a_r   <= a_r >> NIBBLE_W;
            b_r   <= b_r >> NIBBLE_W;
            cnt   <= cnt + CW'(1);
            if (last_nibble) begin
                sum  <= r_next;
                cout <= add_cout;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (NIBBLES=4) with
// hand-computed sums, latency, pulse-width, ignore-while-busy and reset checks.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;

    int checks;
    int errors;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Presents one start pulse; returns at the falling edge right after the accepting edge.
    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
        @(negedge clk);
        start = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        cin   = 1'b0;
    endtask

    task automatic waitDone(output int latency, output int busy_cycles);
        latency     = 0;
        busy_cycles = 0;
        while (!done && latency < 20) begin
            if (busy) busy_cycles = busy_cycles + 1;
            @(negedge clk);
            latency = latency + 1;
        end
    endtask

    task automatic countDone(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) pulses = pulses + 1;
        end
    endtask

    initial begin
        int lat;
        int bc;
        int pulses;
        int hold_bad;

        checks = 0;
        errors = 0;
        start  = 1'b0;
        a      = 16'h0;
        b      = 16'h0;
        cin    = 1'b0;
        rst_n  = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);
        checkOutput("reset_sum",  32'(sum),  32'h0);
        checkOutput("reset_cout", 32'(cout), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic add");
        applyStimulus(16'h0001, 16'h0002, 1'b0);
        waitDone(lat, bc);
        checkOutput("basic_latency", 32'(lat), 32'd4);
        checkOutput("basic_busy_cycles", 32'(bc), 32'd4);
        checkOutput("basic_sum",  32'(sum),  32'h0003);
        checkOutput("basic_cout", 32'(cout), 32'h0);
        checkOutput("basic_busy_at_done", 32'(busy), 32'h0);
        @(negedge clk);
        checkOutput("basic_done_one_cycle", 32'(done), 32'h0);
        checkOutput("basic_sum_hold_idle", 32'(sum), 32'h0003);

        $display("[TB] full carry ripple");
        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        waitDone(lat, bc);
        checkOutput("ripple_latency", 32'(lat), 32'd4);
        checkOutput("ripple_sum",  32'(sum),  32'h0000);
        checkOutput("ripple_cout", 32'(cout), 32'h1);
        @(negedge clk);

        $display("[TB] carry-in and top overflow");
        applyStimulus(16'h8000, 16'h8000, 1'b1);
        waitDone(lat, bc);
        checkOutput("ovf_latency", 32'(lat), 32'd4);
        checkOutput("ovf_sum",  32'(sum),  32'h0001);
        checkOutput("ovf_cout", 32'(cout), 32'h1);
        @(negedge clk);

        $display("[TB] back-to-back");
        applyStimulus(16'h00FF, 16'h0001, 1'b0);
        waitDone(lat, bc);
        checkOutput("b2b_first_latency", 32'(lat), 32'd4);
        checkOutput("b2b_first_sum",  32'(sum),  32'h0100);
        checkOutput("b2b_first_cout", 32'(cout), 32'h0);
        applyStimulus(16'hA5A5, 16'h5A5A, 1'b1);
        checkOutput("b2b_no_overlap_done", 32'(done), 32'h0);
        checkOutput("b2b_no_overlap_busy", 32'(busy), 32'h1);
        hold_bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (sum !== 16'h0100) hold_bad = hold_bad + 1;
            @(negedge clk);
        end
        waitDone(lat, bc);
        checkOutput("b2b_sum_hold", 32'(hold_bad), 32'd0);
        checkOutput("b2b_second_latency", 32'(lat + 3), 32'd4);
        checkOutput("b2b_second_sum",  32'(sum),  32'h0000);
        checkOutput("b2b_second_cout", 32'(cout), 32'h1);
        @(negedge clk);

        $display("[TB] start while busy");
        applyStimulus(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        cin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        waitDone(lat, bc);
        checkOutput("busy_start_latency", 32'(lat + 2), 32'd4);
        checkOutput("busy_start_sum",  32'(sum),  32'h2345);
        checkOutput("busy_start_cout", 32'(cout), 32'h0);
        countDone(8, pulses);
        checkOutput("busy_start_no_second_done", 32'(pulses), 32'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(16'h5555, 16'h1111, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_busy", 32'(busy), 32'h0);
        checkOutput("rstmid_done", 32'(done), 32'h0);
        checkOutput("rstmid_sum",  32'(sum),  32'h0);
        checkOutput("rstmid_cout", 32'(cout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        countDone(8, pulses);
        checkOutput("rstmid_no_done", 32'(pulses), 32'd0);
        applyStimulus(16'h0005, 16'h0003, 1'b0);
        waitDone(lat, bc);
        checkOutput("rstmid_after_latency", 32'(lat), 32'd4);
        checkOutput("rstmid_after_sum",  32'(sum),  32'h0008);
        checkOutput("rstmid_after_cout", 32'(cout), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
